jericalla_fetch: RTL and testbench

Instruction-issue stage directly upstream of the JericallaEvo datapath. It holds a small loadable program memory of 17-bit instructions and a program counter, and drives the datapath's `Instruccion` input once per cycle. It inserts bubbles when an instruction would read a register that an in-flight instruction has not yet written back. Run, drain and done phases are sequenced by an FSM.

---
 rtl/jericalla_pkg.sv | 51 +++++
 rtl/jericalla_hazard_sb.sv | 39 +++
 rtl/jericalla_fetch.sv | 147 ++++++++++++++
 tb/tb_jericalla_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jericalla_pkg.sv
// Shared constants, instruction field helpers and FSM encoding for the
// Jericalla instruction-issue stage.
package jericalla_pkg;

    localparam int JF_DEPTH     = 32;
    localparam int JF_AW        = 5;
    localparam int JF_HAZ_DEPTH = 2;
    localparam int IW           = 17;
    localparam int RW           = 5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SLT = 2'b10;
    localparam logic [1:0] OP_SW  = 2'b11;

    localparam int OP_MSB  = 16;
    localparam int OP_LSB  = 15;
    localparam int WA_MSB  = 14;
    localparam int WA_LSB  = 10;
    localparam int RA1_MSB = 9;
    localparam int RA1_LSB = 5;
    localparam int RA2_MSB = 4;
    localparam int RA2_LSB = 0;

    // ADD R0 <- R0,R0; R0 is scratch so this never creates a dependency.
    localparam logic [IW-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    function automatic logic [1:0] instr_op(input logic [IW-1:0] i);
        return i[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [RW-1:0] instr_wa(input logic [IW-1:0] i);
        return i[WA_MSB:WA_LSB];
    endfunction

    function automatic logic [RW-1:0] instr_ra1(input logic [IW-1:0] i);
        return i[RA1_MSB:RA1_LSB];
    endfunction

    function automatic logic [RW-1:0] instr_ra2(input logic [IW-1:0] i);
        return i[RA2_MSB:RA2_LSB];
    endfunction

endpackage

// File: rtl/jericalla_hazard_sb.sv
// Shift register of the most recently issued write addresses and the
// read-after-write compare against the candidate instruction's sources.
module jericalla_hazard_sb
    import jericalla_pkg::*;
#(
    parameter int HAZ_DEPTH = JF_HAZ_DEPTH
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          clear,
    input  logic          shift_en,
    input  logic [RW-1:0] shift_wa,
    input  logic [RW-1:0] ra1,
    input  logic [RW-1:0] ra2,
    output logic          hazard
);

    logic [RW-1:0] sb [HAZ_DEPTH];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < HAZ_DEPTH; i++) sb[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < HAZ_DEPTH; i++) sb[i] <= '0;
        end else if (shift_en) begin
            sb[0] <= shift_wa;
            for (int i = 1; i < HAZ_DEPTH; i++) sb[i] <= sb[i-1];
        end
    end

    // A zero entry never matches, which also makes RA = 0 harmless.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb[i] != '0 && (sb[i] == ra1 || sb[i] == ra2)) hazard = 1'b1;
        end
    end

endmodule

// File: rtl/jericalla_fetch.sv
// Instruction-issue stage: loadable program memory, PC, hazard bubbles and a
// run/drain/done sequencer feeding the JericallaEvo datapath.
module jericalla_fetch
    import jericalla_pkg::*;
#(
    parameter int DEPTH     = JF_DEPTH,
    parameter int AW        = JF_AW,
    parameter int HAZ_DEPTH = JF_HAZ_DEPTH
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          Start,
    input  logic [AW:0]   ProgLen,
    input  logic          ProgWE,
    input  logic [AW-1:0] ProgAddr,
    input  logic [IW-1:0] ProgData,
    input  logic          Stall,
    output logic [IW-1:0] Instruccion,
    output logic          Valid,
    output logic [AW-1:0] PC,
    output logic          Busy,
    output logic          Done,
    output logic [7:0]    BubbleCount
);

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PC_MAX  = AW'(DEPTH - 1);

    logic [IW-1:0] mem [DEPTH];
    fetch_state_e  state;
    logic [AW-1:0] pc;
    logic [AW:0]   issued;
    logic [AW:0]   prog_len;
    logic [1:0]    drain_cnt;
    logic [IW-1:0] instr_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    bub_cnt;

    logic [IW-1:0] cur;
    logic          hazard;
    logic          idle_like;
    logic          sb_clear;
    logic          sb_shift;
    logic [RW-1:0] sb_wa;

    assign cur       = mem[pc];
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign sb_clear  = !Stall && idle_like && Start;
    assign sb_shift  = !Stall && (state == ST_RUN || state == ST_DRAIN);
    // Bubbles and stores occupy a slot but write no register.
    assign sb_wa     = (state == ST_RUN && !hazard && instr_op(cur) != OP_SW) ? instr_wa(cur) : '0;

    // Writes land on the same edge as an accepted Start, so the run sees them.
    always_ff @(posedge CLK) begin
        if (ProgWE && idle_like && !Stall) mem[ProgAddr] <= ProgData;
    end

    jericalla_hazard_sb #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_hazard_sb (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .clear    (sb_clear),
        .shift_en (sb_shift),
        .shift_wa (sb_wa),
        .ra1      (instr_ra1(cur)),
        .ra2      (instr_ra2(cur)),
        .hazard   (hazard)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            issued    <= '0;
            prog_len  <= '0;
            drain_cnt <= '0;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bub_cnt   <= '0;
        end else if (!Stall) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        pc      <= '0;
                        issued  <= '0;
                        bub_cnt <= '0;
                        if (ProgLen == '0) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state    <= ST_RUN;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            prog_len <= (ProgLen > LEN_MAX) ? LEN_MAX : ProgLen;
                        end
                    end
                end
                ST_RUN: begin
                    if (hazard) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        if (bub_cnt != 8'hFF) bub_cnt <= bub_cnt + 8'd1;
                    end else begin
                        instr_q <= cur;
                        valid_q <= 1'b1;
                        issued  <= issued + (AW+1)'(1);
                        if (pc != PC_MAX) pc <= pc + AW'(1);
                        if (issued + (AW+1)'(1) == prog_len) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Three writeback bubbles, then one edge to settle into DONE.
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                    if (drain_cnt == 2'd3) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Valid qualifies Instruccion on every cycle; there is no ready, and Stall freezes everything.
    assign Instruccion = instr_q;
    assign Valid       = valid_q;
    assign PC          = pc;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign BubbleCount = bub_cnt;

endmodule

// File: tb/tb_jericalla_fetch.sv
// Self-checking bench for jericalla_fetch: directed vector table, hand-written
// corner sequences and randomized programs against a slot-schedule model.
module tb_jericalla_fetch;
    import jericalla_pkg::*;

    logic        CLK;
    logic        RST_n;
    logic        Start;
    logic [5:0]  ProgLen;
    logic        ProgWE;
    logic [4:0]  ProgAddr;
    logic [16:0] ProgData;
    logic        Stall;
    logic [16:0] Instruccion;
    logic        Valid;
    logic [4:0]  PC;
    logic        Busy;
    logic        Done;
    logic [7:0]  BubbleCount;

    jericalla_fetch dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .Start       (Start),
        .ProgLen     (ProgLen),
        .ProgWE      (ProgWE),
        .ProgAddr    (ProgAddr),
        .ProgData    (ProgData),
        .Stall       (Stall),
        .Instruccion (Instruccion),
        .Valid       (Valid),
        .PC          (PC),
        .Busy        (Busy),
        .Done        (Done),
        .BubbleCount (BubbleCount)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] prog_m [32];
    logic [32:0] exp_q[$];

    typedef struct {
        logic [16:0] i0;
        logic [16:0] i1;
        logic [16:0] i2;
        int          len;
        int          stall_at;
        int          exp_bub;
        int          exp_edges;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [16:0] mk(input int op, input int wa, input int r1, input int r2);
        return {2'(op), 5'(wa), 5'(r1), 5'(r2)};
    endfunction

    function automatic logic [32:0] pk(input logic [16:0] i, input logic v, input int pc,
                                       input logic b, input logic d, input int bub);
        return {i, v, 5'(pc), b, d, 8'(bub)};
    endfunction

    function automatic logic [32:0] observed();
        return {Instruccion, Valid, PC, Busy, Done, BubbleCount};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Each program instruction j lands in slot s[j]: one after its predecessor,
    // and at least 3 slots after any earlier register-writing producer it reads.
    task automatic build_exp(input int n);
        int s[32];
        int last;
        int issued;
        int j;
        int bub;
        logic [16:0] ins;
        logic        v;
        exp_q.delete();
        if (n == 0) begin
            exp_q.push_back(pk(17'd0, 1'b0, 0, 1'b0, 1'b1, 0));
            return;
        end
        exp_q.push_back(pk(17'd0, 1'b0, 0, 1'b1, 1'b0, 0));
        for (int k = 0; k < n; k++) begin
            s[k] = (k == 0) ? 0 : s[k-1] + 1;
            for (int p = 0; p < k; p++) begin
                if (prog_m[p][16:15] != 2'b11 && prog_m[p][14:10] != 5'd0 &&
                    (prog_m[k][9:5] == prog_m[p][14:10] || prog_m[k][4:0] == prog_m[p][14:10]))
                    if (s[p] + 3 > s[k]) s[k] = s[p] + 3;
            end
        end
        last   = s[n-1];
        issued = 0;
        j      = 0;
        for (int t = 0; t <= last; t++) begin
            if (j < n && s[j] == t) begin
                ins = prog_m[j];
                v   = 1'b1;
                issued++;
                j++;
            end else begin
                ins = 17'd0;
                v   = 1'b0;
            end
            exp_q.push_back(pk(ins, v, (issued > 31) ? 31 : issued, 1'b1, 1'b0, t + 1 - issued));
        end
        bub = last + 1 - n;
        for (int d = 0; d < 3; d++)
            exp_q.push_back(pk(17'd0, 1'b0, (n > 31) ? 31 : n, 1'b1, 1'b0, bub));
        exp_q.push_back(pk(17'd0, 1'b0, (n > 31) ? 31 : n, 1'b0, 1'b1, bub));
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_mem(input int a, input logic [16:0] d);
        ProgWE   = 1'b1;
        ProgAddr = 5'(a);
        ProgData = d;
        @(posedge CLK);
        #1;
        ProgWE   = 1'b0;
        prog_m[a] = d;
    endtask

    task automatic run_prog(input string tag, input int len, input int stall_at, input bit mid_poke,
                            output int done_edge, output logic [7:0] bub_final);
        int          cyc;
        logic [32:0] cur_exp;
        build_exp((len > 32) ? 32 : len);
        ProgLen = 6'(len);
        Start   = 1'b1;
        @(posedge CLK);
        #1;
        Start     = 1'b0;
        ProgWE    = 1'b0;
        done_edge = -1;
        cyc       = 1;
        cur_exp   = exp_q.pop_front();
        check($sformatf("%s c%0d", tag, cyc), observed(), cur_exp);
        if (Done && done_edge < 0) done_edge = cyc;
        while (exp_q.size() > 0) begin
            if (cyc == stall_at) begin
                Stall = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(posedge CLK);
                    #1;
                    check($sformatf("%s stall%0d", tag, i), observed(), cur_exp);
                end
                Stall = 1'b0;
            end
            if (mid_poke && cyc == 2) begin
                ProgWE   = 1'b1;
                ProgAddr = 5'd0;
                ProgData = ~prog_m[0];
                Start    = 1'b1;
                ProgLen  = 6'd0;
            end
            @(posedge CLK);
            #1;
            ProgWE  = 1'b0;
            Start   = 1'b0;
            cyc++;
            cur_exp = exp_q.pop_front();
            check($sformatf("%s c%0d", tag, cyc), observed(), cur_exp);
            if (Done && done_edge < 0) done_edge = cyc;
        end
        bub_final = BubbleCount;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int          de;
        logic [7:0]  bf;
        logic [16:0] nv;

        RST_n = 1'b0; Start = 1'b0; ProgLen = '0; ProgWE = 1'b0;
        ProgAddr = '0; ProgData = '0; Stall = 1'b0;
        #3;
        check("reset_async_init", observed(), 33'd0);
        @(posedge CLK);
        #1;
        check("reset_held", observed(), 33'd0);
        RST_n = 1'b1;

        vecs[0] = '{mk(0,4,1,2),  mk(1,5,6,7),  mk(2,8,9,10), 3, -1, 0, 8};
        vecs[1] = '{mk(0,4,1,2),  mk(1,5,4,3),  mk(0,0,0,0),  2,  3, 2, 9};
        vecs[2] = '{mk(0,4,1,2),  mk(0,6,1,2),  mk(3,0,4,7),  3, -1, 1, 9};
        vecs[3] = '{mk(0,0,1,2),  mk(1,3,0,0),  mk(2,4,0,1),  3, -1, 0, 8};
        vecs[4] = '{mk(3,9,5,6),  mk(0,1,9,9),  mk(2,2,3,0),  3, -1, 0, 8};
        vecs[5] = '{mk(0,4,1,2),  mk(1,5,6,7),  mk(2,8,9,10), 0, -1, 0, 1};

        for (int v = 0; v < 6; v++) begin
            write_mem(0, vecs[v].i0);
            write_mem(1, vecs[v].i1);
            write_mem(2, vecs[v].i2);
            run_prog($sformatf("vec%0d", v), vecs[v].len, vecs[v].stall_at, 1'b0, de, bf);
            check($sformatf("vec%0d bubbles", v), 33'(bf), 33'(vecs[v].exp_bub));
            check($sformatf("vec%0d done_edge", v), 33'(de), 33'(vecs[v].exp_edges));
        end

        // Write and Start during RUN are ignored; the rerun proves memory unchanged.
        write_mem(0, mk(0,4,1,2));
        write_mem(1, mk(1,5,6,7));
        write_mem(2, mk(2,8,9,10));
        run_prog("poke_run", 3, -1, 1'b1, de, bf);
        run_prog("poke_rerun", 3, -1, 1'b0, de, bf);

        // Write on the same edge as Start is visible to that run.
        nv         = mk(1,12,13,14);
        prog_m[0]  = nv;
        ProgWE     = 1'b1;
        ProgAddr   = 5'd0;
        ProgData   = nv;
        run_prog("we_start", 3, -1, 1'b0, de, bf);

        // Asynchronous reset in the middle of a run.
        ProgLen = 6'd3;
        Start   = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_pre_busy", 33'(Busy), 33'd1);
        #2;
        RST_n = 1'b0;
        #1;
        check("rst_mid_async", observed(), 33'd0);
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        run_prog("rst_rerun", 3, -1, 1'b0, de, bf);

        // Randomized programs with a small register range to provoke hazards.
        for (int r = 0; r < 12; r++) begin
            int len;
            int st;
            for (int a = 0; a < 32; a++)
                write_mem(a, mk($urandom_range(0,3), $urandom_range(0,7),
                                $urandom_range(0,7), $urandom_range(0,7)));
            len = (r % 4 == 3) ? $urandom_range(33,63) : $urandom_range(1,32);
            st  = (r % 2 == 0) ? $urandom_range(2,12) : -1;
            run_prog($sformatf("rnd%0d", r), len, st, 1'b0, de, bf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
